// File: rtl/cascade_logic_chain.sv
// cascade_logic_chain: debounced switches feeding chained registered 4-input truth-table stages, one LED per stage plus settled flag
module cascade_logic_chain #(
  parameter int STAGES = 2,
  parameter logic [STAGES*16-1:0] TRUTH = {16'hFFFE, 16'h8000},
  parameter int DEBOUNCE = 4,
  localparam int SW_W = 3*STAGES+1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [SW_W-1:0]   sw,
  output logic [STAGES-1:0] led,
  output logic              settled
);
  localparam int CW = $clog2(DEBOUNCE)+1;
  localparam int SCW = $clog2(STAGES+1);
  logic [SW_W-1:0] s1, s2, db, db_nx;
  logic [CW-1:0] cnt [SW_W];
  logic [CW-1:0] cnt_nx [SW_W];
  logic [SCW-1:0] scnt;
  logic [STAGES:0] a_in;
  logic [3:0] sel [STAGES];
  logic chg;
  always_comb begin
    db_nx = db;
    cnt_nx = cnt;
    for (int k = 0; k < SW_W; k++) begin
      cnt_nx[k] = (s2[k] == db[k] || cnt[k] == CW'(DEBOUNCE-1)) ? '0 : cnt[k] + 1'b1;
      db_nx[k] = (s2[k] != db[k] && cnt[k] == CW'(DEBOUNCE-1)) ? s2[k] : db[k];
    end
  end
  assign chg = db_nx != db;
  assign a_in = {led, db[0]};
  always_comb begin
    for (int i = 0; i < STAGES; i++) sel[i] = {db[3*i+1 +: 3], a_in[i]};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
      db <= '0;
      for (int k = 0; k < SW_W; k++) cnt[k] <= '0;
      led <= '0;
      scnt <= SCW'(STAGES);
      settled <= 1'b0;
    end else begin
      s1 <= sw;
      s2 <= s1;
      db <= db_nx;
      cnt <= cnt_nx;
      for (int i = 0; i < STAGES; i++) led[i] <= TRUTH[16*i + int'(sel[i])];
      scnt <= chg ? SCW'(STAGES) : (scnt != '0 ? scnt - 1'b1 : scnt);
      settled <= !chg && scnt == '0;
    end
  end
endmodule

// File: doc/cascade_logic_chain.md
Name: cascade_logic_chain

Overview:
- Parametrised, registered successor to the two-stage switch-to-LED logic cascade.
- Debounces a bank of slide switches, then feeds them through STAGES chained 4-input logic functions. Each function is defined by a truth-table parameter.
- Stage 0 consumes 4 switches. Each later stage consumes the previous stage's output plus 3 new switches.
- Every stage output is registered and drives one LED. A settled flag tells the board when the LEDs reflect the current switch state.

Parameters:
- STAGES, 2, number of chained 4-input function stages (1..8).
- TRUTH, {16'hFFFE, 16'h8000}, STAGES*16-bit vector. Bits [16i+15:16i] are the truth table of stage i, indexed by {D,C,B,A}.
- DEBOUNCE, 4, consecutive synchronised cycles a switch must hold a new value before it is accepted (>=1).
- SW_W, 3*STAGES+1, derived switch count. Not overridden.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- sw  input  SW_W  raw asynchronous slide switches.
- led  output  STAGES  led[i] = registered output of stage i.
- settled  output  1  high when led reflects current debounced switches.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset (at the edge where reset=1):
  - both synchroniser flops, debounced value db, and debounce counters cleared to 0.
  - led = 0.
  - settle counter loaded with STAGES.
  - settled = 0.
  - Reset asserted mid-debounce or mid-propagation discards all in-flight state.
- Synchroniser: per-bit 2-flop chain, sw -> s1 -> s2.
- Debouncer, per bit k:
  - if s2[k]==db[k], cnt[k] clears to 0;
  - otherwise cnt[k] increments;
  - on the edge where the mismatch persists and cnt[k]==DEBOUNCE-1, db[k] takes s2[k] and cnt[k] clears.
  - A mismatch lasting fewer than DEBOUNCE cycles is dropped.
  - Counter width is clog2(DEBOUNCE)+1 and never wraps.
- Stage i inputs:
  - i=0: A=db[0], B=db[1], C=db[2], D=db[3].
  - i>0: A=led[i-1] (registered), B=db[3i+1], C=db[3i+2], D=db[3i+3].
- Stage i register: led[i] <= TRUTH[16i + {D,C,B,A}] every cycle when reset=0.
- Latency, for a switch change applied just after edge 0 and held:
  - db updates at edge DEBOUNCE+2.
  - Stage i, if it uses that switch directly, updates at edge DEBOUNCE+3.
  - A change rippling from stage j reaches led[i] at edge DEBOUNCE+3+(i-j).
  - Full-chain worst case is DEBOUNCE+2+STAGES.
- Settle counter:
  - loads STAGES on any edge where any db bit changes;
  - otherwise decrements while nonzero.
  - settled <= (counter==0 and no db change this edge).
  - After reset, settled rises at edge STAGES+1, when led holds f(all-zero).
- Simultaneous events:
  - Multiple db bits changing on the same edge cause a single reload.
  - A db change while the counter is nonzero reloads to STAGES (no accumulation).
- Constant or unused inputs need no special handling. All truth-table bits are legal.

Test Plan:
- STAGES=2, DEBOUNCE=4, default TRUTH (stage0 AND4, stage1 OR4).
- Reset test: hold reset 3 cycles, sw=0, then release -> led=00 throughout, settled=0 until edge 3 after release, then 1.
- Debounce latency: after settle, set sw=7'b0001111 just after edge 0 -> db[3:0]=1111 at edge 6; led[0]=1 at edge 7; led[1]=1 at edge 8; settled=0 from edge 6 and back to 1 at edge 9.
- Glitch rejection: pulse sw[0] 0->1 for 3 cycles then back to 0 -> db, led and settled unchanged (settled stays 1).
- Stage-1 direct input: sw=7'b0010000 -> led[1]=1 at edge 7, led[0] stays 0. Clearing sw[4] -> led[1]=0 seven edges later.
- Reset mid-operation: set sw=7'b0001111, assert reset at edge 4 -> db, led and settled all 0. After release, the full debounce delay applies again (db at release+6).
- Parametrised: STAGES=3, TRUTH stage2=16'h6996 (XOR4), sw=10'b1110001111 -> led=3'b011. Stage2 = XOR(1,1,1,1) = 0 and appears one edge after led[1]. Toggling sw[7] -> led[2]=1.
